// File: rtl/event_readout_fifo.sv
// Event readout FIFO: buffers {peak, tail, time} events from the pulse detector and
// presents the oldest one to HPS PIOs. The HPS acknowledges each entry by toggling
// hps_read_bit, which is synchronized into this clock domain before being edge-detected.
module event_readout_fifo #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     evt_valid,
  input  logic [31:0]              evt_peak,
  input  logic [31:0]              evt_tail,
  input  logic [25:0]              evt_time,
  input  logic                     hps_read_bit,
  output logic [31:0]              ddc_peak_out,
  output logic [31:0]              ddc_tail_out,
  output logic [25:0]              ddc_time_out,
  output logic                     data_valid,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [15:0]              overflow_count
);

  localparam int unsigned PtrW     = $clog2(DEPTH);
  localparam int unsigned CntW     = PtrW + 1;
  // Edges after reset during which the edge reference just tracks the synchronizer.
  localparam int unsigned PrimeLen = SYNC_STAGES + 1;
  localparam int unsigned PrimeW   = $clog2(PrimeLen + 1);

  logic [89:0]            mem_q [DEPTH];
  logic [89:0]            evt_entry;
  logic [89:0]            head_q, head_d;
  logic                   valid_q, valid_d;
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]        count_q, count_d;
  logic [15:0]            ovf_q, ovf_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_ref_q;
  logic [PrimeW-1:0]      prime_cnt_q;
  logic                   primed;
  logic                   pop_req;
  logic                   pop;
  logic                   push;

  assign evt_entry = {evt_peak, evt_tail, evt_time};
  assign primed    = (prime_cnt_q == PrimeW'(PrimeLen));
  assign pop_req   = primed && (sync_q[SYNC_STAGES-1] ^ edge_ref_q);

  // Synchronizer, edge reference and post-reset priming counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q      <= '0;
      edge_ref_q  <= 1'b0;
      prime_cnt_q <= '0;
    end else begin
      sync_q[0] <= hps_read_bit;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      edge_ref_q <= sync_q[SYNC_STAGES-1];
      if (!primed) begin
        prime_cnt_q <= prime_cnt_q + PrimeW'(1);
      end
    end
  end

  // Next-state for pointers, count, presented head and overflow counter.
  always_comb begin
    pop      = pop_req && (count_q != '0);
    // Pop is applied first, so a full buffer still accepts a push on a pop edge.
    push     = evt_valid && ((count_q != CntW'(DEPTH)) || pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q;

    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    if (evt_valid && !push && (ovf_q != 16'hffff)) begin
      ovf_d = ovf_q + 16'd1;
    end

    if (pop) begin
      if (count_q == CntW'(1)) begin
        // Last entry leaves; a coincident push becomes the head directly.
        head_d  = push ? evt_entry : '0;
        valid_d = push;
      end else begin
        head_d  = mem_q[rd_ptr_d];
        valid_d = 1'b1;
      end
    end else if (push && (count_q == '0)) begin
      head_d  = evt_entry;
      valid_d = 1'b1;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  // Entry storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= evt_entry;
    end
  end

  assign ddc_peak_out   = head_q[89:58];
  assign ddc_tail_out   = head_q[57:26];
  assign ddc_time_out   = head_q[25:0];
  assign data_valid     = valid_q;
  assign fifo_count     = count_q;
  assign overflow_count = ovf_q;

endmodule

// File: tb/tb_event_readout_fifo.sv
// Bench for event_readout_fifo: directed scenarios plus a random phase, all checked
// every cycle against a queue-based model of the buffer and the acknowledge delay.
module tb_event_readout_fifo;

  localparam int DEPTH = 16;
  localparam int SYNC  = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          evt_valid;
  logic [31:0]   evt_peak;
  logic [31:0]   evt_tail;
  logic [25:0]   evt_time;
  logic          hps_read_bit;
  logic [31:0]   ddc_peak_out;
  logic [31:0]   ddc_tail_out;
  logic [25:0]   ddc_time_out;
  logic          data_valid;
  logic [CW-1:0] fifo_count;
  logic [15:0]   overflow_count;

  always #5 clk = ~clk;

  event_readout_fifo #(
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .evt_valid      (evt_valid),
    .evt_peak       (evt_peak),
    .evt_tail       (evt_tail),
    .evt_time       (evt_time),
    .hps_read_bit   (hps_read_bit),
    .ddc_peak_out   (ddc_peak_out),
    .ddc_tail_out   (ddc_tail_out),
    .ddc_time_out   (ddc_time_out),
    .data_valid     (data_valid),
    .fifo_count     (fifo_count),
    .overflow_count (overflow_count)
  );

  typedef logic [89:0] entry_t;

  entry_t q[$];       // model contents, head at index 0
  logic   hist[$];    // hps_read_bit as sampled at each edge since reset release
  int     ovf;
  int     errors = 0;
  int     checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    entry_t head;
    head = (q.size() != 0) ? q[0] : '0;
    chk({tag, "_peak"},  64'(ddc_peak_out),   64'(head[89:58]));
    chk({tag, "_tail"},  64'(ddc_tail_out),   64'(head[57:26]));
    chk({tag, "_time"},  64'(ddc_time_out),   64'(head[25:0]));
    chk({tag, "_valid"}, 64'(data_valid),     64'(q.size() != 0));
    chk({tag, "_count"}, 64'(fifo_count),     64'(q.size()));
    chk({tag, "_ovf"},   64'(overflow_count), 64'(ovf));
  endtask

  // One clock edge: model the edge, then compare 1 time unit later.
  task automatic step();
    bit pop;
    @(posedge clk);
    hist.push_back(hps_read_bit);
    pop = 1'b0;
    // An acknowledge takes effect SYNC edges after the edge that first saw it.
    if (hist.size() >= SYNC + 2) begin
      pop = (hist[hist.size() - 1 - SYNC] != hist[hist.size() - 2 - SYNC]);
    end
    if (pop && q.size() > 0) void'(q.pop_front());
    if (evt_valid) begin
      if (q.size() < DEPTH) q.push_back({evt_peak, evt_tail, evt_time});
      else if (ovf < 65535) ovf++;
    end
    #1;
    check_all("cyc");
    evt_valid = 1'b0;
  endtask

  task automatic push_evt(input logic [31:0] p, input logic [31:0] t, input logic [25:0] tm);
    evt_valid = 1'b1;
    evt_peak  = p;
    evt_tail  = t;
    evt_time  = tm;
    step();
  endtask

  task automatic toggle();
    hps_read_bit = ~hps_read_bit;
    step();
  endtask

  task automatic apply_reset(input bit evt);
    #2;
    reset     = 1'b1;
    evt_valid = evt;
    evt_peak  = 32'hdead;
    #1;
    q.delete();
    hist.delete();
    ovf = 0;
    check_all("async_rst");
    repeat (2) @(posedge clk);
    #1;
    reset     = 1'b0;
    evt_valid = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    evt_valid    = 1'b0;
    evt_peak     = '0;
    evt_tail     = '0;
    evt_time     = '0;
    hps_read_bit = 1'b0;
    ovf          = 0;
    #1;
    apply_reset(1'b0);
    repeat (5) step();

    // Single event visible the cycle after it is sampled.
    push_evt(32'h11, 32'h22, 26'h33);
    chk("first_peak",  64'(ddc_peak_out), 64'h11);
    chk("first_tail",  64'(ddc_tail_out), 64'h22);
    chk("first_time",  64'(ddc_time_out), 64'h33);
    chk("first_count", 64'(fifo_count),   64'd1);

    // Three entries acknowledged one by one, then an acknowledge on empty.
    push_evt(32'hb0b0, 32'hb1b1, 26'hb2b2);
    push_evt(32'hc0c0, 32'hc1c1, 26'hc2c2);
    repeat (6) step();
    repeat (3) begin
      toggle();
      repeat (9) step();
    end
    chk("drained_valid", 64'(data_valid), 64'd0);
    toggle();
    repeat (9) step();
    push_evt(32'h77, 32'h88, 26'h99);
    chk("after_empty_pop_count", 64'(fifo_count), 64'd1);
    toggle();
    repeat (5) step();

    // Overfill by two.
    for (int i = 1; i <= 18; i++) begin
      push_evt(32'(i), 32'(i * 3), 26'(i * 5));
    end
    chk("full_count", 64'(fifo_count),     64'd16);
    chk("full_ovf",   64'(overflow_count), 64'd2);

    // Push coincident with the internal pop while full.
    toggle();
    step();
    push_evt(32'habc, 32'hdef, 26'h123);
    chk("coinc_count", 64'(fifo_count),     64'd16);
    chk("coinc_ovf",   64'(overflow_count), 64'd2);
    repeat (4) step();

    // Drain everything; order is checked every cycle.
    repeat (17) begin
      toggle();
      repeat (3) step();
    end
    chk("drain_valid", 64'(data_valid), 64'd0);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) < 12) hps_read_bit = ~hps_read_bit;
      evt_valid = ($urandom_range(0, 99) < 40);
      evt_peak  = $urandom;
      evt_tail  = $urandom;
      evt_time  = 26'($urandom);
      step();
    end

    // Reset mid-operation with a pending acknowledge and hps_read_bit held high.
    if (hps_read_bit) begin
      hps_read_bit = 1'b0;
      repeat (5) step();
    end
    push_evt(32'h5, 32'h6, 26'h7);
    hps_read_bit = 1'b1;
    step();
    apply_reset(1'b1);
    push_evt(32'ha1, 32'ha2, 26'ha3);
    push_evt(32'hb1, 32'hb2, 26'hb3);
    repeat (6) step();
    chk("held_head", 64'(ddc_peak_out), 64'ha1);
    chk("held_count", 64'(fifo_count), 64'd2);
    hps_read_bit = 1'b0;
    repeat (5) step();
    chk("held_second", 64'(ddc_peak_out), 64'hb1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/event_readout_fifo.md
EVENT_READOUT_FIFO -- requirements
Module: event_readout_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning event capacity including the presented head entry (power of 2, 4..64).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth on hps_read_bit.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is in this domain.
REQ-004 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port evt_valid, input, 1, a one-cycle strobe from the upstream pulse detector marking a completed event.
REQ-006 SHALL have port evt_peak, input, 32, the event peak value, sampled with evt_valid.
REQ-007 SHALL have port evt_tail, input, 32, the event tail integral, sampled with evt_valid.
REQ-008 SHALL have port evt_time, input, 26, the event timestamp, sampled with evt_valid.
REQ-009 SHALL have port hps_read_bit, input, 1, a toggle from the HPS PIO; each edge acknowledges the presented entry.
REQ-010 SHALL have port ddc_peak_out, output, 32, the head-entry peak, feeding the ddc_peak_out PIO.
REQ-011 SHALL have port ddc_tail_out, output, 32, the head-entry tail, feeding the ddc_tail_out PIO.
REQ-012 SHALL have port ddc_time_out, output, 26, the head-entry time, feeding the ddc_time_out PIO.
REQ-013 SHALL have port data_valid, output, 1, high while a head entry is presented.
REQ-014 SHALL have port fifo_count, output, clog2(DEPTH)+1, the number of stored entries including the head.
REQ-015 SHALL have port overflow_count, output, 16, the number of events dropped while full.

Function
REQ-016 SHALL store each event {peak, tail, time} as one 90-bit entry, delivered in arrival order.
REQ-017 SHALL push on the clk edge where evt_valid=1 and the buffer is not full (effective count after any same-edge pop < DEPTH).
REQ-018 SHALL present the head entry from registers; a push into an empty buffer is visible on ddc_*_out, with data_valid=1, in the cycle after the sampling edge.
REQ-019 SHALL pass hps_read_bit through SYNC_STAGES flops followed by one edge-reference flop; any change of the synchronized value is a pop request lasting exactly one cycle.
REQ-020 SHALL make pop latency fixed at SYNC_STAGES+1 edges from the hps_read_bit change to the next head (or empty state) being visible.
REQ-021 SHALL remove the head on a pop request when count>0; the next entry becomes the head on the same edge.
REQ-022 SHALL ignore a pop request when count=0: no pointer, count or output change.
REQ-023 SHALL process a simultaneous push and pop with the pop first: count unchanged, and the pushed entry is accepted even at count=DEPTH.
REQ-024 SHALL make the pushed entry the head directly when pushed and popped simultaneously at count=1.
REQ-025 SHALL drop an event on evt_valid at count=DEPTH with no pop, and increment overflow_count, saturating at 65535.
REQ-026 SHALL wrap read and write pointers modulo DEPTH; fifo_count SHALL never exceed DEPTH.
REQ-027 SHALL drive ddc_peak_out, ddc_tail_out and ddc_time_out to zero whenever data_valid=0.
REQ-028 SHALL update data_valid and fifo_count on the same edge as the pointer change they reflect.

Reset
REQ-029 SHALL asynchronously clear on reset assertion: all outputs, pointers, count, overflow_count, synchronizer and edge-reference flops; storage contents are don't-care.
REQ-030 SHALL load the first synchronized hps_read_bit value after reset deassertion into the edge-reference flop without generating a pop, whatever the level of hps_read_bit.
REQ-031 SHALL discard all entries on reset asserted mid-operation, including a pending pop in the synchronizer; evt_valid coincident with reset SHALL be ignored.

Verification
REQ-032 SHALL cover this scenario: after reset, one event peak=0x11, tail=0x22, time=0x33 -> outputs show 0x11/0x22/0x33, data_valid=1 and fifo_count=1 in the next cycle.
REQ-033 SHALL cover this scenario: 3 events A,B,C pushed, then hps_read_bit toggled 3 times, spaced 10 cycles -> head A, then B, then C, then zeros with data_valid=0; each change occurs exactly 3 edges after its toggle (SYNC_STAGES=2).
REQ-034 SHALL cover this scenario: 18 events with no reads at DEPTH=16 -> fifo_count=16 and overflow_count=2; the entries read out are events 1..16 in order.
REQ-035 SHALL cover this scenario: full buffer with evt_valid coincident with the internal pop request -> fifo_count stays 16, overflow_count unchanged, new event read out last.
REQ-036 SHALL cover this scenario: hps_read_bit held 1 through reset release, with 2 events then pushed -> no pop occurs and the head is the first event; toggle to 0 -> the second event is presented.
REQ-037 SHALL cover this scenario: toggle hps_read_bit while empty, then push one event -> event presented, fifo_count=1, no underflow.
